// File: rtl/lsu_pkg.sv
// Shared types, constants and address helpers for the LSU bus bridge.
package lsu_pkg;

   localparam int unsigned BUS_W           = 32;
   localparam int unsigned ACK_TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_DONE
   } lsu_state_e;

   // funct3[1:0] selects the access size, funct3[2] selects zero-extension
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;
   localparam int unsigned F3_UNSIGNED = 2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   function automatic logic [63:0] align_addr(input logic [2:0] f3, input logic [63:0] a);
      case (f3[1:0])
         SZ_B:    return a;
         SZ_H:    return {a[63:1], 1'b0};
         SZ_W:    return {a[63:2], 2'b00};
         default: return {a[63:3], 3'b000};
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] lo);
      case (f3[1:0])
         SZ_B:    return 1'b0;
         SZ_H:    return lo[0];
         SZ_W:    return |lo[1:0];
         default: return |lo;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: write replication, byte enables, load shift and extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]       funct3_i,
   input  logic [1:0]       off_i,
   input  logic             hi_i,
   input  logic [63:0]      wdata_i,
   input  logic [BUS_W-1:0] rdata_i,
   input  logic [BUS_W-1:0] lo_i,
   output logic [BUS_W-1:0] wdata_o,
   output logic [3:0]       be_o,
   output logic [63:0]      ldata_o
);

   logic [BUS_W-1:0] shifted;
   logic             uns;

   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      uns     = funct3_i[F3_UNSIGNED];
      wdata_o = '0;
      be_o    = '0;
      ldata_o = '0;
      case (funct3_i[1:0])
         SZ_B: begin
            wdata_o = {4{wdata_i[7:0]}};
            be_o    = 4'b0001 << off_i;
            ldata_o = uns ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            wdata_o = {2{wdata_i[15:0]}};
            be_o    = 4'b0011 << {off_i[1], 1'b0};
            ldata_o = uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         end
         SZ_W: begin
            wdata_o = wdata_i[31:0];
            be_o    = 4'hF;
            ldata_o = uns ? {32'd0, shifted} : {{32{shifted[31]}}, shifted};
         end
         default: begin
            wdata_o = hi_i ? wdata_i[63:32] : wdata_i[31:0];
            be_o    = 4'hF;
            ldata_o = {rdata_i, lo_i};
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Multi-cycle load/store bridge from the core's memory stage to a 32-bit req/ack bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses abort with err instead of being force-aligned.
module lsu_bus_bridge
   import lsu_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_read,
   input  logic             req_write,
   input  logic [2:0]       funct3,
   input  logic [63:0]      addr,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata,
   output logic             stall,
   output logic             err,
   output logic             bus_req,
   output logic             bus_we,
   output logic [63:0]      bus_addr,
   output logic [BUS_W-1:0] bus_wdata,
   output logic [3:0]       bus_be,
   input  logic [BUS_W-1:0] bus_rdata,
   input  logic             bus_ack
);

   lsu_state_e state_q, state_d;

   logic [7:0]       cnt_q, cnt_d;
   logic [BUS_W-1:0] lo_q, lo_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [63:0]      addr_q, addr_d;
   logic [BUS_W-1:0] wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic [63:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [63:0]      aligned;
   logic             req_any, req_both, is_d, ack, timeout, misal;
   logic [BUS_W-1:0] la_wdata;
   logic [3:0]       la_be;
   logic [63:0]      la_ldata;

   assign aligned  = align_addr(funct3, addr);
   assign req_any  = req_read | req_write;
   assign req_both = req_read & req_write;
   assign is_d     = (funct3[1:0] == SZ_D);
   assign ack      = bus_ack & req_q;
   assign timeout  = ({1'b0, cnt_q} + 9'd1) >= 9'(ACK_TIMEOUT);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misal = misaligned(funct3, addr[2:0]);
`else
   assign misal = 1'b0;
`endif

   // In BEAT0 the aligner prepares the upper word for the following D beat
   lsu_lane_align u_align (
      .funct3_i (funct3),
      .off_i    (aligned[1:0]),
      .hi_i     (state_q == ST_BEAT0),
      .wdata_i  (wdata),
      .rdata_i  (bus_rdata),
      .lo_i     (lo_q),
      .wdata_o  (la_wdata),
      .be_o     (la_be),
      .ldata_o  (la_ldata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_both || (req_any && misal)) state_d = ST_DONE;
            else if (req_any)                   state_d = ST_BEAT0;
         end
         ST_BEAT0: begin
            if (ack)          state_d = is_d ? ST_BEAT1 : ST_DONE;
            else if (timeout) state_d = ST_DONE;
         end
         ST_BEAT1: begin
            if (ack || timeout) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      stall   = !rst && req_any && (state_q != ST_DONE);
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_both || (req_any && misal)) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end else if (req_any) begin
               req_d   = 1'b1;
               we_d    = req_write;
               addr_d  = {aligned[63:2], 2'b00};
               wdata_d = la_wdata;
               be_d    = la_be;
               cnt_d   = '0;
            end
         end
         ST_BEAT0, ST_BEAT1: begin
            if (ack && state_q == ST_BEAT0 && is_d) begin
               lo_d    = bus_rdata;
               addr_d  = addr_q + 64'd4;
               wdata_d = la_wdata;
               cnt_d   = '0;
            end else if (ack) begin
               req_d   = 1'b0;
               rdata_d = we_q ? '0 : la_ldata;
               err_d   = 1'b0;
            end else if (timeout) begin
               req_d   = 1'b0;
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         default: begin
            rdata_d = '0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         cnt_q   <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_be    = be_q;
   assign rdata     = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed scoreboard bench for lsu_bus_bridge; the bench plays the bus slave.
module tb_lsu_bus_bridge;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_read, req_write;
   logic [2:0]  funct3;
   logic [63:0] addr, wdata, rdata, bus_addr;
   logic        stall, err, bus_req, bus_we, bus_ack;
   logic [31:0] bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   always #5 clk = ~clk;

   lsu_bus_bridge #(.ACK_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
      .stall(stall), .err(err), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   typedef struct { logic [63:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } beat_t;
   typedef struct { logic [63:0] rdata; logic err; } res_t;

   beat_t beat_q[$];
   res_t  res_q[$];
   int    checks = 0;
   int    failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic [63:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
      beat_t b;
      b.addr = a; b.we = we; b.be = be; b.wdata = wd;
      beat_q.push_back(b);
   endtask

   task automatic push_res(input logic [63:0] rd, input logic e);
      res_t r;
      r.rdata = rd; r.err = e;
      res_q.push_back(r);
   endtask

   // Drives one access, acks each beat after `waits` wait cycles, checks beats and result.
   task automatic run(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] wd, input int unsigned waits,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input int exp_stall, input int exp_req);
      int unsigned stall_n = 0, req_n = 0, wc = 0, beat = 0;
      bit done = 0;
      beat_t eb;
      res_t  er;
      @(negedge clk);
      req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
      for (int c = 0; c < 64 && !done; c++) begin
         #1;
         bus_ack = 1'b0;
         if (!stall) begin
            done = 1;
            chk({tag, ".result_expected"}, 64'(res_q.size() > 0), 64'd1);
            if (res_q.size() > 0) begin
               er = res_q.pop_front();
               chk({tag, ".rdata"}, rdata, er.rdata);
               chk({tag, ".err"}, 64'(err), 64'(er.err));
            end
         end else begin
            stall_n++;
            if (bus_req) begin
               req_n++;
               if (wc == waits) begin
                  bus_ack = 1'b1;
                  bus_rdata = (beat == 0) ? d0 : d1;
                  beat++;
                  wc = 0;
                  chk({tag, ".beat_expected"}, 64'(beat_q.size() > 0), 64'd1);
                  if (beat_q.size() > 0) begin
                     eb = beat_q.pop_front();
                     chk({tag, ".bus_addr"}, bus_addr, eb.addr);
                     chk({tag, ".bus_we"}, 64'(bus_we), 64'(eb.we));
                     chk({tag, ".bus_be"}, 64'(bus_be), 64'(eb.be));
                     chk({tag, ".bus_wdata"}, 64'(bus_wdata), 64'(eb.wdata));
                  end
               end else begin
                  wc++;
               end
            end
            @(negedge clk);
         end
      end
      chk({tag, ".completed"}, 64'(done), 64'd1);
      chk({tag, ".stall_cycles"}, 64'(stall_n), 64'(exp_stall));
      chk({tag, ".req_cycles"}, 64'(req_n), 64'(exp_req));
      chk({tag, ".beats_left"}, 64'(beat_q.size()), 64'd0);
      beat_q.delete();
      res_q.delete();
      req_read = 1'b0; req_write = 1'b0; bus_ack = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, ".rdata_cleared"}, rdata, 64'd0);
   endtask

   initial begin
      rst = 1'b1; req_read = 1'b0; req_write = 1'b0; funct3 = '0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      #12;
      chk("reset.bus_req", 64'(bus_req), 64'd0);
      chk("reset.bus_be", 64'(bus_be), 64'd0);
      chk("reset.bus_addr", bus_addr, 64'd0);
      chk("reset.rdata", rdata, 64'd0);
      chk("reset.err", 64'(err), 64'd0);
      chk("reset.stall", 64'(stall), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      push_beat(64'h1000, 1'b1, 4'hF, 32'h11223344);
      push_res(64'd0, 1'b0);
      run("sw", 1'b0, 1'b1, F3_W, 64'h1000, 64'hCAFEF00D_11223344, 0, 32'h0, 32'h0, 2, 1);

      push_beat(64'h1000, 1'b0, 4'b1000, 32'h0);
      push_res(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      run("lb", 1'b1, 1'b0, F3_B, 64'h1003, 64'd0, 0, 32'h8000_0000, 32'h0, 2, 1);

      push_beat(64'h1000, 1'b0, 4'b1000, 32'h0);
      push_res(64'h80, 1'b0);
      run("lbu", 1'b1, 1'b0, F3_BU, 64'h1003, 64'd0, 0, 32'h8000_0000, 32'h0, 2, 1);

      push_beat(64'h2000, 1'b0, 4'hF, 32'h0);
      push_beat(64'h2004, 1'b0, 4'hF, 32'h0);
      push_res(64'h0123_4567_DEAD_BEEF, 1'b0);
      run("ld", 1'b1, 1'b0, F3_D, 64'h2000, 64'd0, 2, 32'hDEADBEEF, 32'h01234567, 7, 6);

      push_beat(64'h2008, 1'b1, 4'hF, 32'h89AB_CDEF);
      push_beat(64'h200C, 1'b1, 4'hF, 32'h0123_4567);
      push_res(64'd0, 1'b0);
      run("sd", 1'b0, 1'b1, F3_D, 64'h2008, 64'h0123_4567_89AB_CDEF, 0, 32'h0, 32'h0, 3, 2);

      push_beat(64'h1000, 1'b1, 4'b0100, 32'hA5A5_A5A5);
      push_res(64'd0, 1'b0);
      run("sb", 1'b0, 1'b1, F3_B, 64'h1002, 64'h0000_00A5, 1, 32'h0, 32'h0, 3, 2);

      push_beat(64'h1004, 1'b1, 4'b1100, 32'hBEEF_BEEF);
      push_res(64'd0, 1'b0);
      run("sh", 1'b0, 1'b1, F3_H, 64'h1006, 64'h0000_BEEF, 0, 32'h0, 32'h0, 2, 1);

      push_beat(64'h1000, 1'b0, 4'b1100, 32'h0);
      push_res(64'h8001, 1'b0);
      run("lhu", 1'b1, 1'b0, F3_HU, 64'h1002, 64'd0, 0, 32'h8001_0000, 32'h0, 2, 1);

      push_beat(64'h1004, 1'b0, 4'hF, 32'h0);
      push_res(64'hFFFF_FFFF_8000_0001, 1'b0);
      run("lw", 1'b1, 1'b0, F3_W, 64'h1004, 64'd0, 0, 32'h8000_0001, 32'h0, 2, 1);

      push_beat(64'h1004, 1'b0, 4'hF, 32'h0);
      push_res(64'h8000_0001, 1'b0);
      run("lwu", 1'b1, 1'b0, F3_WU, 64'h1004, 64'd0, 0, 32'h8000_0001, 32'h0, 2, 1);

      push_res(64'd0, 1'b1);
      run("lw_timeout", 1'b1, 1'b0, F3_W, 64'h1008, 64'd0, 100, 32'h1234_5678, 32'h0, 9, 8);

      push_res(64'd0, 1'b1);
      run("rd_and_wr", 1'b1, 1'b1, F3_W, 64'h1000, 64'd0, 0, 32'h0, 32'h0, 1, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      push_res(64'd0, 1'b1);
      run("lh_misalign", 1'b1, 1'b0, F3_H, 64'h1001, 64'd0, 0, 32'h1234_8001, 32'h0, 1, 0);
`else
      push_beat(64'h1000, 1'b0, 4'b0011, 32'h0);
      push_res(64'hFFFF_FFFF_FFFF_8001, 1'b0);
      run("lh_misalign", 1'b1, 1'b0, F3_H, 64'h1001, 64'd0, 0, 32'h1234_8001, 32'h0, 2, 1);
`endif

      // Reset during BEAT1 of a doubleword store
      @(negedge clk);
      req_write = 1'b1; funct3 = F3_D; addr = 64'h3000; wdata = 64'h5555_6666_7777_8888;
      @(negedge clk);
      #1;
      chk("rst_mid.beat0_req", 64'(bus_req), 64'd1);
      bus_ack = 1'b1;
      @(negedge clk);
      #1;
      bus_ack = 1'b0;
      chk("rst_mid.beat1_req", 64'(bus_req), 64'd1);
      chk("rst_mid.beat1_addr", bus_addr, 64'h3004);
      chk("rst_mid.beat1_wdata", 64'(bus_wdata), 64'h5555_6666);
      rst = 1'b1;
      #1;
      chk("rst_mid.bus_req", 64'(bus_req), 64'd0);
      chk("rst_mid.stall", 64'(stall), 64'd0);
      chk("rst_mid.bus_addr", bus_addr, 64'd0);
      @(negedge clk);
      req_write = 1'b0;
      rst = 1'b0;

      push_beat(64'h1010, 1'b1, 4'hF, 32'h0BAD_F00D);
      push_res(64'd0, 1'b0);
      run("sw_after_rst", 1'b0, 1'b1, F3_W, 64'h1010, 64'h0000_0000_0BAD_F00D, 0, 32'h0, 32'h0, 2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
